// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: accepts a WIDTH-bit word on start/ready, shifts it out MSB first
// on a registered line, idles for GAP_CYCLES, then pulses done for one cycle.
module serial_pattern_tx #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned GAP_CYCLES = 1,
    parameter bit          IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             x_out,
    output logic             done,
    output logic             busy,
    output logic [1:0]       currState,
    output logic [7:0]       frames
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CW-1:0] BIT_LOAD = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             x_q, x_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [GW-1:0]    gapcnt_q, gapcnt_d;
    logic [7:0]       frames_q, frames_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            x_q      <= IDLE_BIT;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            frames_q <= frames_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        frames_d = frames_q;
        case (state_q)
            StIdle: begin
                x_d = IDLE_BIT;
                if (start) begin
                    // First bit goes straight onto the line; the shifter holds the rest.
                    state_d  = StShift;
                    x_d      = data[WIDTH-1];
                    shreg_d  = data << 1;
                    bitcnt_d = BIT_LOAD;
                end
            end
            StShift: begin
                if (bitcnt_q != '0) begin
                    x_d      = shreg_q[WIDTH-1];
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q - CW'(1);
                end else begin
                    x_d = IDLE_BIT;
                    if (GAP_CYCLES > 0) begin
                        state_d  = StGap;
                        gapcnt_d = GAP_LOAD;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StGap: begin
                x_d = IDLE_BIT;
                if (gapcnt_q != '0) begin
                    gapcnt_d = gapcnt_q - GW'(1);
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                x_d      = IDLE_BIT;
                state_d  = StIdle;
                frames_d = frames_q + 8'd1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ready     = (state_q == StIdle);
    assign busy      = (state_q == StShift) || (state_q == StGap);
    assign done      = (state_q == StDone);
    assign currState = state_q;
    assign x_out     = x_q;
    assign frames    = frames_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: three variants (gap 1, gap 0, idle-high line) share stimulus and
// are compared every cycle against a frame-position model, plus directed tables and sequences.
module tb_serial_pattern_tx;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] data = 4'd0;

    logic [2:0] x_o, rdy_o, done_o, busy_o;
    logic [1:0] st_o [3];
    logic [7:0] fr_o [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(4), .GAP_CYCLES(1), .IDLE_BIT(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data), .ready(rdy_o[0]),
        .x_out(x_o[0]), .done(done_o[0]), .busy(busy_o[0]), .currState(st_o[0]),
        .frames(fr_o[0])
    );
    serial_pattern_tx #(.WIDTH(4), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) u_dut_g0 (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data), .ready(rdy_o[1]),
        .x_out(x_o[1]), .done(done_o[1]), .busy(busy_o[1]), .currState(st_o[1]),
        .frames(fr_o[1])
    );
    serial_pattern_tx #(.WIDTH(4), .GAP_CYCLES(1), .IDLE_BIT(1'b1)) u_dut_i1 (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data), .ready(rdy_o[2]),
        .x_out(x_o[2]), .done(done_o[2]), .busy(busy_o[2]), .currState(st_o[2]),
        .frames(fr_o[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int gap_of(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    function automatic logic ib_of(input int i);
        return (i == 2);
    endfunction

    // Model: pos = cycles since the accepting edge (0 = idle), frames counted on leaving done.
    int         pos [3] = '{0, 0, 0};
    logic [3:0] word [3] = '{4'd0, 4'd0, 4'd0};
    logic [7:0] mfr [3] = '{8'd0, 8'd0, 8'd0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                pos[i] <= 0;
                mfr[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pos[i] == 0) begin
                    if (start) begin
                        pos[i]  <= 1;
                        word[i] <= data;
                    end
                end else if (pos[i] == W + gap_of(i) + 1) begin
                    pos[i] <= 0;
                    mfr[i] <= mfr[i] + 8'd1;
                end else begin
                    pos[i] <= pos[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic       ex, er, ed, eb;
                logic [1:0] es;
                int         p;
                p = pos[i];
                ex = ib_of(i); er = 1'b0; ed = 1'b0; eb = 1'b0; es = 2'd0;
                if (p == 0) begin
                    er = 1'b1;
                end else if (p <= W) begin
                    ex = word[i][W-p]; eb = 1'b1; es = 2'd1;
                end else if (p <= W + gap_of(i)) begin
                    eb = 1'b1; es = 2'd2;
                end else begin
                    ed = 1'b1; es = 2'd3;
                end
                check($sformatf("dut%0d x_out", i), 32'(x_o[i]), 32'(ex));
                check($sformatf("dut%0d ready", i), 32'(rdy_o[i]), 32'(er));
                check($sformatf("dut%0d done", i), 32'(done_o[i]), 32'(ed));
                check($sformatf("dut%0d busy", i), 32'(busy_o[i]), 32'(eb));
                check($sformatf("dut%0d currState", i), 32'(st_o[i]), 32'(es));
                check($sformatf("dut%0d frames", i), 32'(fr_o[i]), 32'(mfr[i]));
            end
        end
    end

    // Cycles 1..7 after the accepting edge, MSB = cycle 1.
    typedef struct {
        logic [3:0] word;
        logic [6:0] x0;
        logic [6:0] xg;
        logic [6:0] xi;
    } vec_t;

    vec_t       vecs [5];
    logic [6:0] done0, doneg, rdy0, rdyg;
    int         ndone;
    logic [3:0] line;
    logic [7:0] fr_before;

    initial begin
        vecs[0] = '{4'b1001, 7'b1001000, 7'b1001000, 7'b1001111};
        vecs[1] = '{4'b1110, 7'b1110000, 7'b1110000, 7'b1110111};
        vecs[2] = '{4'b0110, 7'b0110000, 7'b0110000, 7'b0110111};
        vecs[3] = '{4'b0000, 7'b0000000, 7'b0000000, 7'b0000111};
        vecs[4] = '{4'b1111, 7'b1111000, 7'b1111000, 7'b1111111};
        done0 = 7'b0000010;
        doneg = 7'b0000100;
        rdy0  = 7'b0000001;
        rdyg  = 7'b0000011;

        // Reset state
        #12;
        check("rst x_out", 32'(x_o), 32'b100);
        check("rst ready", 32'(rdy_o), 32'b111);
        check("rst done", 32'(done_o), 32'b000);
        check("rst busy", 32'(busy_o), 32'b000);
        check("rst state", 32'(st_o[0]), 32'd0);
        check("rst frames", 32'(fr_o[0]), 32'd0);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Directed frames
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            check("pre x idle-low", 32'(x_o[0]), 32'd0);
            check("pre x idle-high", 32'(x_o[2]), 32'd1);
            start = 1'b1;
            data  = vecs[v].word;
            for (int c = 1; c <= 7; c++) begin
                @(negedge clk);
                start = 1'b0;
                check($sformatf("vec%0d c%0d x gap1", v, c), 32'(x_o[0]), 32'(vecs[v].x0[7-c]));
                check($sformatf("vec%0d c%0d x gap0", v, c), 32'(x_o[1]), 32'(vecs[v].xg[7-c]));
                check($sformatf("vec%0d c%0d x idle1", v, c), 32'(x_o[2]), 32'(vecs[v].xi[7-c]));
                check($sformatf("vec%0d c%0d done gap1", v, c), 32'(done_o[0]),
                      32'(done0[7-c]));
                check($sformatf("vec%0d c%0d done gap0", v, c), 32'(done_o[1]),
                      32'(doneg[7-c]));
                check($sformatf("vec%0d c%0d ready gap1", v, c), 32'(rdy_o[0]),
                      32'(rdy0[7-c]));
                check($sformatf("vec%0d c%0d ready gap0", v, c), 32'(rdy_o[1]),
                      32'(rdyg[7-c]));
            end
        end
        check("frames after table", 32'(fr_o[0]), 32'd5);

        // Start pulse mid-frame is ignored
        @(negedge clk);
        fr_before = fr_o[0];
        start = 1'b1;
        data  = 4'b1001;
        ndone = 0;
        line  = 4'd0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = (c == 2);
            data  = (c == 2) ? 4'b1111 : 4'b0000;
            if (c <= 4) line = {line[2:0], x_o[0]};
            if (done_o[0]) ndone++;
        end
        check("midframe start line", 32'(line), 32'b1001);
        check("midframe start done count", 32'(ndone), 32'd1);
        check("midframe start frames", 32'(fr_o[0]), 32'(fr_before + 8'd1));

        // Asynchronous reset in cycle 2 of a frame
        @(negedge clk);
        start = 1'b1;
        data  = 4'b1011;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst x_out", 32'(x_o), 32'b100);
        check("async rst state", 32'(st_o[0]), 32'd0);
        check("async rst ready", 32'(rdy_o), 32'b111);
        check("async rst done", 32'(done_o), 32'b000);
        check("async rst frames", 32'(fr_o[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start held high for 256 frames
        @(negedge clk);
        start = 1'b1;
        data  = 4'b1010;
        ndone = 0;
        for (int c = 0; c < 2400 && ndone < 256; c++) begin
            @(negedge clk);
            if (done_o[0]) ndone++;
        end
        start = 1'b0;
        check("held start done count", 32'(ndone), 32'd256);
        @(negedge clk);
        check("held start frames wrap", 32'(fr_o[0]), 32'd0);
        repeat (8) @(negedge clk);

        // Randomised traffic with one mid-run reset
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            data  = 4'($urandom);
            if (c == 1000) begin
                #($urandom_range(1, 4)) rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
